dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory between the pipeline core's load/store port (port C) and a program/debug loader port (port L). It sits between the core/loader and the data memory wrapper, serialises accesses with round-robin fairness, holds each granted transaction stable until the memory returns `valid`, and routes the response back to the winner. A timeout watchdog guarantees forward progress if the memory never answers.

## Interface
- `ADDR_W`, 8, word-address width; matches the data memory's `address[9:2]`.
- `TIMEOUT`, 16, maximum cycles in ACCESS before the transaction is aborted with an error; legal range 1..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `c_request`, `l_request`  in  1  transaction request; held high until that port's `valid`.
- `c_we_re`, `l_we_re`  in  1  1 = store, 0 = load.
- `c_address`, `l_address`  in  ADDR_W  word address.
- `c_data_in`, `l_data_in`  in  32  store data.
- `c_mask`, `l_mask`  in  4  byte enables.
- `c_load`, `l_load`  in  1  load qualifier forwarded to memory.
- `c_valid`, `l_valid`  out  1  one-cycle completion pulse to the granted port.
- `c_err`, `l_err`  out  1  asserted with `valid` when the transaction timed out.
- `c_data_out`, `l_data_out`  out  32  load result, valid while `valid` is high.
- `m_request`, `m_we_re`, `m_load`  out  1  memory-side controls.
- `m_address`  out  ADDR_W;  `m_data_in`  out  32;  `m_mask`  out  4.
- `m_valid`  in  1  memory completion.
- `m_data_out`  in  32  memory read data.

## Operation
- FSM: IDLE, ACCESS, RESP.
- IDLE: if any request is high, pick a winner, latch its `we_re/address/data_in/mask/load` into holding registers, record `grant` (0 = C, 1 = L), clear the timeout counter, go to ACCESS. If no request, stay.
- Round-robin: `last_grant` register. When both ports request, the port not equal to `last_grant` wins. When one port requests, it wins. `last_grant` updates on leaving RESP. Its reset value is 1, so C wins the first tie.
- ACCESS: `m_request`=1 and all `m_*` outputs are driven from the holding registers, stable for the whole state.
  - `m_valid`=1: capture `m_data_out` into the response register, clear `err`, go to RESP. For stores the response register is loaded with 0.
  - Counter reaches `TIMEOUT-1` without `m_valid`: load the response register with 0, set `err`, go to RESP.
  - Counter width is 8 bits and it never wraps.
- RESP: `m_request`=0. The granted port sees `valid`=1 and `err` equal to the stored flag; `data_out` equals the response register. The other port's `valid/err` stay 0. Next state is IDLE.
- `data_out` is 0 whenever that port's `valid` is 0.
- Requester contract: keep `request` and all fields stable until `valid`, and drop `request` in the cycle after `valid`. The earliest re-request is 2 cycles after `valid`.
- Request changes while in ACCESS or RESP are ignored; arbitration happens only in IDLE.

## Timing
- Reset values: state IDLE, `last_grant`=1, counter 0, all outputs 0 (`m_request`, `m_*`, `valid`, `err`, `data_out`).
- Reset mid-transaction: the FSM returns to IDLE on the next edge, `m_request` falls that edge, and no `valid` is issued for the aborted access.
- Latency, with the request sampled in IDLE at cycle 0:
  - `m_request` rises at cycle 1.
  - If `m_valid` arrives at cycle k ≥ 1, the port's `valid` is at cycle k+1.
  - Minimum request-to-valid is 2 cycles. For memory that answers one cycle after request (`m_valid` at cycle 2), `valid` is at cycle 3.
- Timeout: with no `m_valid`, ACCESS occupies cycles 1..TIMEOUT and `valid`+`err` appear at cycle TIMEOUT+1.
- A simultaneous `m_valid` and counter expiry counts as success (`err`=0).
- Throughput: one transaction per (ACCESS length + 2) cycles. An IDLE cycle always separates transactions.

## Test plan
- Single core load, address 0x10, memory returns 0xDEADBEEF with `m_valid` 1 cycle after `m_request` -> `c_valid` pulses at cycle 3 with `c_data_out`=0xDEADBEEF; `l_valid` stays 0.
- Both ports request at cycle 0 right after reset (C store to 0x04 with data 0x11223344 and mask 0xF; L load from 0x08) -> C is served first with `m_we_re`=1 and `m_mask`=0xF; L is served next. `m_address` shows 0x04 then 0x08.
- Both ports request continuously for 6 transactions -> grants alternate C, L, C, L, C, L; neither port gets two consecutive grants.
- Memory never asserts `m_valid` with `TIMEOUT`=4 -> `l_valid`=1 and `l_err`=1 at cycle 5, `l_data_out`=0, `m_request` low at cycle 5; the next request is served normally.
- `rst` asserted at cycle 2 of an ACCESS -> `m_request`=0 from the next edge, no `c_valid`; after release, a tie goes to C.
- L's fields change while C is in ACCESS -> the `m_*` outputs remain C's latched values until RESP.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data memory between core (C) and loader (L) ports.
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_request,
  input  logic              c_we_re,
  input  logic [ADDR_W-1:0] c_address,
  input  logic [31:0]       c_data_in,
  input  logic [3:0]        c_mask,
  input  logic              c_load,
  output logic              c_valid,
  output logic              c_err,
  output logic [31:0]       c_data_out,
  input  logic              l_request,
  input  logic              l_we_re,
  input  logic [ADDR_W-1:0] l_address,
  input  logic [31:0]       l_data_in,
  input  logic [3:0]        l_mask,
  input  logic              l_load,
  output logic              l_valid,
  output logic              l_err,
  output logic [31:0]       l_data_out,
  output logic              m_request,
  output logic              m_we_re,
  output logic              m_load,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_data_in,
  output logic [3:0]        m_mask,
  input  logic              m_valid,
  input  logic [31:0]       m_data_out
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);
  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d, grant_q, grant_d;
  logic              we_q, we_d, load_q, load_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, resp_q, resp_d;
  logic [3:0]        mask_q, mask_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              win, acc, rsp;
  assign acc = state_q == ACCESS;
  assign rsp = state_q == RESP;
  // On a tie the port that did not win last time goes first.
  assign win = (c_request && l_request) ? ~last_grant_q : l_request;
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    load_d       = load_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    resp_d       = resp_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    if (state_q == IDLE && (c_request || l_request)) begin
      state_d = ACCESS;
      grant_d = win;
      we_d    = win ? l_we_re : c_we_re;
      load_d  = win ? l_load : c_load;
      addr_d  = win ? l_address : c_address;
      wdata_d = win ? l_data_in : c_data_in;
      mask_d  = win ? l_mask : c_mask;
      cnt_d   = '0;
    end else if (acc) begin
      if (m_valid) begin
        state_d = RESP;
        resp_d  = we_q ? '0 : m_data_out;
        err_d   = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        state_d = RESP;
        resp_d  = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (rsp) begin
      state_d      = IDLE;
      last_grant_d = grant_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      load_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      resp_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      load_q       <= load_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end
  assign m_request  = acc;
  assign m_we_re    = acc & we_q;
  assign m_load     = acc & load_q;
  assign m_address  = acc ? addr_q : '0;
  assign m_data_in  = acc ? wdata_q : '0;
  assign m_mask     = acc ? mask_q : '0;
  assign c_valid    = rsp & ~grant_q;
  assign l_valid    = rsp & grant_q;
  assign c_err      = c_valid & err_q;
  assign l_err      = l_valid & err_q;
  assign c_data_out = c_valid ? resp_q : '0;
  assign l_data_out = l_valid ? resp_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized bench with a transaction-schedule reference model of the arbiter.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic c_request = 0, c_we_re = 0, c_load = 0, l_request = 0, l_we_re = 0, l_load = 0, m_valid = 0;
  logic [AW-1:0] c_address = 0, l_address = 0;
  logic [31:0] c_data_in = 0, l_data_in = 0, m_data_out = 0;
  logic [3:0] c_mask = 0, l_mask = 0;
  logic c_valid, l_valid, c_err, l_err, m_request, m_we_re, m_load;
  logic [31:0] c_data_out, l_data_out, m_data_in;
  logic [AW-1:0] m_address;
  logic [3:0] m_mask;
  int checks = 0, failures = 0, cyc = 0;
  bit busy = 0, g = 0, last = 1, we_h = 0, ld_h = 0, err_h = 0, obs_err = 0;
  bit rst_now = 0, fix_rd = 0, rnd = 0;
  logic [AW-1:0] ad_h = 0;
  logic [31:0] dt_h = 0, rd_h = 0, rd_val = 0, obs_data = 0;
  logic [3:0] mk_h = 0;
  int s = 0, d = 0, a = 0, dly = 2, obs_cyc = 0;
  int want[2], cool[2];
  bit pend[2];
  bit grants[$];
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .c_request(c_request), .c_we_re(c_we_re), .c_address(c_address), .c_data_in(c_data_in),
    .c_mask(c_mask), .c_load(c_load), .c_valid(c_valid), .c_err(c_err), .c_data_out(c_data_out),
    .l_request(l_request), .l_we_re(l_we_re), .l_address(l_address), .l_data_in(l_data_in),
    .l_mask(l_mask), .l_load(l_load), .l_valid(l_valid), .l_err(l_err), .l_data_out(l_data_out),
    .m_request(m_request), .m_we_re(m_we_re), .m_load(m_load), .m_address(m_address),
    .m_data_in(m_data_in), .m_mask(m_mask), .m_valid(m_valid), .m_data_out(m_data_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  // One clock: check this cycle's outputs against the schedule, then drive this cycle's inputs.
  task automatic tick();
    bit acc, rsp;
    @(negedge clk);
    cyc++;
    if (busy && cyc == s + a + 2) begin busy = 0; last = g; end
    acc = busy && cyc >= s + 1 && cyc <= s + a;
    rsp = busy && cyc == s + a + 1;
    chk("m_request", m_request, acc);
    if (acc) begin
      chk("m_we_re", m_we_re, we_h);
      chk("m_load", m_load, ld_h);
      chk("m_address", m_address, ad_h);
      chk("m_data_in", m_data_in, dt_h);
      chk("m_mask", m_mask, mk_h);
    end
    chk("c_valid", c_valid, rsp && !g);
    chk("l_valid", l_valid, rsp && g);
    chk("c_err", c_err, rsp && !g && err_h);
    chk("l_err", l_err, rsp && g && err_h);
    chk("c_data_out", c_data_out, (rsp && !g) ? rd_h : 32'd0);
    chk("l_data_out", l_data_out, (rsp && g) ? rd_h : 32'd0);
    if (c_valid || l_valid) begin
      obs_cyc = cyc; obs_err = c_valid ? c_err : l_err; obs_data = c_valid ? c_data_out : l_data_out;
    end
    if (rsp) begin pend[g] = 0; cool[g] = cyc + 2; grants.push_back(g); end
    if (rnd) begin
      {c_we_re, c_load, l_we_re, l_load} = 4'($urandom);
      c_address = AW'($urandom); l_address = AW'($urandom);
      c_data_in = $urandom; l_data_in = $urandom;
      c_mask = 4'($urandom); l_mask = 4'($urandom);
      dly = $urandom_range(1, 6);
      rst_now = $urandom_range(0, 59) == 0;
      for (int p = 0; p < 2; p++) if (want[p] == 0 && $urandom_range(0, 3) == 0) want[p] = 1;
    end
    m_data_out = fix_rd ? rd_val : $urandom;
    m_valid = busy && d <= TO && cyc == s + d;
    if (m_valid) rd_h = we_h ? 32'd0 : m_data_out;
    for (int p = 0; p < 2; p++)
      if (!pend[p] && want[p] > 0 && cyc >= cool[p]) begin pend[p] = 1; want[p]--; end
    c_request = pend[0];
    l_request = pend[1];
    rst = rst_now;
    if (rst_now) begin
      busy = 0; last = 1;
    end else if (!busy && (c_request || l_request)) begin
      g = (c_request && l_request) ? !last : l_request;
      busy = 1; s = cyc; d = dly; a = d < TO ? d : TO;
      we_h = g ? l_we_re : c_we_re; ld_h = g ? l_load : c_load;
      ad_h = g ? l_address : c_address; dt_h = g ? l_data_in : c_data_in;
      mk_h = g ? l_mask : c_mask;
      err_h = d > TO; rd_h = 0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((busy || pend[0] || pend[1] || want[0] > 0 || want[1] > 0) && n < 300) begin tick(); n++; end
    chk("drain_bound", 32'(n < 300), 1);
    tick();
  endtask
  initial begin
    rst_now = 1;
    repeat (3) tick();
    rst_now = 0;
    c_we_re = 0; c_load = 1; c_address = 8'h10; c_mask = 4'hF;
    fix_rd = 1; rd_val = 32'hDEADBEEF; dly = 2; want[0] = 1;
    drain();
    chk("t1_latency", 32'(obs_cyc - s), 3);
    chk("t1_data", obs_data, 32'hDEADBEEF);
    fix_rd = 0; rst_now = 1; tick(); rst_now = 0;
    grants.delete();
    c_we_re = 1; c_load = 0; c_address = 8'h04; c_data_in = 32'h11223344; c_mask = 4'hF;
    l_we_re = 0; l_load = 1; l_address = 8'h08; l_data_in = 0; l_mask = 4'hF;
    want[0] = 1; want[1] = 1; dly = 2;
    drain();
    chk("t2_count", grants.size(), 2);
    chk("t2_first", 32'(grants[0]), 0);
    chk("t2_second", 32'(grants[1]), 1);
    grants.delete();
    want[0] = 3; want[1] = 3; dly = 3;
    drain();
    chk("t3_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_alternate", 32'(grants[i]), 32'(i % 2));
    want[1] = 1; l_we_re = 0; l_load = 1; l_address = 8'h20; dly = 9;
    drain();
    chk("t4_latency", 32'(obs_cyc - s), TO + 1);
    chk("t4_err", 32'(obs_err), 1);
    chk("t4_data", obs_data, 0);
    want[0] = 1; dly = 3;
    drain();
    chk("t4_next_err", 32'(obs_err), 0);
    chk("t4_next_latency", 32'(obs_cyc - s), 4);
    want[0] = 1; dly = 6;
    for (int i = 0; i < 20 && !busy; i++) tick();
    tick();
    rst_now = 1; tick(); rst_now = 0;
    grants.delete();
    want[1] = 1; dly = 2;
    drain();
    chk("t5_count", grants.size(), 2);
    chk("t5_tie_to_c", 32'(grants[0]), 0);
    rnd = 1;
    repeat (1500) tick();
    rnd = 0; rst_now = 0; want[0] = 0; want[1] = 0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
